// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit BCD adder sequencer: one shared digit-add stage walks the packed
// operands least-significant digit first, one digit per clock.
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry, digit}; the +6 skips the six unused codes above 9.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                               input logic [3:0] y,
                                               input logic       c);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, y} + {4'd0, c};
    if (t > 5'd9) begin
      bcd_digit_add = {1'b1, t[3:0] + 4'd6};
    end else begin
      bcd_digit_add = {1'b0, t[3:0]};
    end
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  state_t             state_q, state_d;
  logic [W-1:0]       a_lat_q, a_lat_d;
  logic [W-1:0]       b_lat_q, b_lat_d;
  logic               cin_lat_q, cin_lat_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               err_q, err_d;

  logic               accept_s;
  logic               last_s;
  logic [W-1:0]       a_sh_s, b_sh_s;
  logic               c_in_s;
  logic [4:0]         add_s;

  assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_s   = (cnt_q == CNT_W'(DIGITS - 1));
  assign a_sh_s   = a_lat_q >> {cnt_q, 2'b00};
  assign b_sh_s   = b_lat_q >> {cnt_q, 2'b00};
  assign c_in_s   = (cnt_q == {CNT_W{1'b0}}) ? cin_lat_q : carry_q;
  assign add_s    = bcd_digit_add(a_sh_s[3:0], b_sh_s[3:0], c_in_s);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_lat_q   <= '0;
      b_lat_q   <= '0;
      cin_lat_q <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_lat_q   <= a_lat_d;
      b_lat_q   <= b_lat_d;
      cin_lat_q <= cin_lat_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (last_s) state_d = DONE;
        else        state_d = RUN;
      end
      DONE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, digit ripple and result accumulation.
  always_comb begin
    a_lat_d   = a_lat_q;
    b_lat_d   = b_lat_q;
    cin_lat_d = cin_lat_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    err_d     = err_q;
    if (accept_s) begin
      a_lat_d   = a;
      b_lat_d   = b;
      cin_lat_d = cin;
      carry_d   = 1'b0;
      cnt_d     = '0;
      sum_d     = '0;
      cout_d    = 1'b0;
      err_d     = has_bad_digit(a) | has_bad_digit(b);
    end else if (state_q == RUN) begin
      // Unprocessed digits are still zero, so OR-ing the new digit in is enough.
      sum_d   = sum_q | (W'(add_s[3:0]) << {cnt_q, 2'b00});
      carry_d = add_s[4];
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_s) begin
        cout_d = add_s[4];
      end else begin
        cout_d = cout_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE:    begin busy = 1'b0; done = 1'b0; end
      RUN:     begin busy = 1'b1; done = 1'b0; end
      DONE:    begin busy = 1'b0; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl (DIGITS=4): vector table plus
// hand-written sequences, results checked through an expected-result queue.
module tb_bcd_serial_adder_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         er;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         er;
  } exp_t;

  vec_t vecs[9];
  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;
  int   nbusy;

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (sum=%h)", sum);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_sum", 32'(sum), 32'(mon_e.s));
        check("sb_cout", 32'(cout), 32'(mon_e.co));
        check("sb_err", 32'(err), 32'(mon_e.er));
      end
    end
  end

  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic [W-1:0] es, input logic eco, input logic eer);
    exp_t e;
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    e.s   = es;
    e.co  = eco;
    e.er  = eer;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input bit drop_start, input logic exp_er,
                           output int lat_o, output int nbusy_o);
    lat_o   = 0;
    nbusy_o = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (drop_start) start = 1'b0;
        check("accept_clears_sum", 32'(sum), 32'h0);
        check("accept_clears_cout", 32'(cout), 32'h0);
        check("accept_err", 32'(err), 32'(exp_er));
      end
      if (busy === 1'b1) nbusy_o++;
      if (done === 1'b1) begin
        lat_o = k;
        check("busy_low_at_done", 32'(busy), 32'h0);
        break;
      end
    end
    if (lat_o == 0) check("done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[4] = '{16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1};
    vecs[5] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[6] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0909, 16'h0191, 1'b0, 16'h1100, 1'b0, 1'b0};
    vecs[8] = '{16'h00F0, 16'h0000, 1'b0, 16'h0150, 1'b0, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single operations from the table.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].er);
      wait_done(1'b1, vecs[i].er, lat, nbusy);
      check("latency", 32'(lat), 32'd5);
      check("busy_cycles", 32'(nbusy), 32'd4);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'h0);
      check("sum_held", 32'(sum), 32'(vecs[i].s));
      check("cout_held", 32'(cout), 32'(vecs[i].co));
      check("err_held", 32'(err), 32'(vecs[i].er));
    end

    // Start held high: a new operation is accepted in every DONE cycle.
    issue(vecs[3].a, vecs[3].b, vecs[3].cin, vecs[3].s, vecs[3].co, vecs[3].er);
    wait_done(1'b0, vecs[3].er, lat, nbusy);
    check("b2b_latency0", 32'(lat), 32'd5);
    issue(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].s, vecs[0].co, vecs[0].er);
    wait_done(1'b0, vecs[0].er, lat, nbusy);
    check("b2b_period1", 32'(lat), 32'd5);
    check("b2b_busy1", 32'(nbusy), 32'd4);
    issue(vecs[2].a, vecs[2].b, vecs[2].cin, vecs[2].s, vecs[2].co, vecs[2].er);
    wait_done(1'b0, vecs[2].er, lat, nbusy);
    check("b2b_period2", 32'(lat), 32'd5);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_idle_busy", 32'(busy), 32'h0);

    // start and operand changes during RUN are ignored.
    issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrun_busy", 32'(busy), 32'h1);
    a     = 16'h5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 16'h0000;
    b     = 16'h9999;
    lat   = 0;
    for (int k = 4; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("midrun_latency", 32'(lat), 32'd5);
    repeat (7) @(negedge clk);
    check("midrun_sum_held", 32'(sum), 32'h3333);

    // Reset during the second RUN cycle aborts without a done pulse.
    issue(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("partial_sum", 32'(sum), 32'h0002);
    check("partial_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    sbq.delete(sbq.size() - 1);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_sum", 32'(sum), 32'h0);
    check("abort_cout", 32'(cout), 32'h0);
    check("abort_err", 32'(err), 32'h0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_still_idle", 32'(busy), 32'h0);
    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Multi-digit BCD addition sequencer. It reuses one single-digit BCD add stage (a + b + carry, with the +6 correction) across DIGITS packed BCD digits, least-significant digit first, one digit per clock. It latches the operands on start, ripples the decimal carry between digits in a register, and presents a packed BCD result with a one-cycle done pulse. It sits between a host or register interface and the digit adder datapath.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal range 1..16)
CNT_W, 4, width of the digit counter; must satisfy 2**CNT_W >= DIGITS

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new addition; sampled only in IDLE or DONE
a  input  4*DIGITS  packed BCD operand A; digit i is a[4i+3:4i]
b  input  4*DIGITS  packed BCD operand B
cin  input  1  decimal carry into digit 0
busy  output  1  high while digits are being processed (RUN state)
done  output  1  one-cycle pulse; sum and cout are valid from this cycle
sum  output  4*DIGITS  packed BCD result; held until the next accepted start
cout  output  1  decimal carry out of the top digit; held with sum
err  output  1  high if any latched input digit was greater than 9; held with sum

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset: state goes to IDLE. busy, done, sum, cout, err all go to 0. The digit counter and carry register go to 0.
- States: IDLE, RUN, DONE.
- Accepting start: start=1 in IDLE or DONE is accepted at that clock edge. On acceptance:
  - a, b and cin are latched into internal registers; later changes on the inputs have no effect.
  - sum, cout and err are cleared to 0.
  - the counter is set to 0.
  - the state goes to RUN.
- start in RUN is ignored, with no effect on the operation in progress.
- RUN, each clock edge, for digit i = counter:
  - t = A_i + B_i + c, computed as 5 bits (c = latched cin for i=0, otherwise the carry register).
  - If t > 9: the digit is (t + 6) mod 16 and the new carry is 1.
  - Otherwise: the digit is t[3:0] and the new carry is 0.
  - The digit is written to sum[4i+3:4i]; the carry register is updated; the counter increments.
  - If i == DIGITS-1: cout takes the new carry and the state goes to DONE.
- err is set at acceptance if any latched digit of A or B is greater than 9. The computation still runs to completion using the same arithmetic rule.
- DONE: done=1 and busy=0 for exactly one cycle, then the state returns to IDLE. A start in DONE is accepted, which allows back-to-back operations.
- busy=1 in every RUN cycle and 0 otherwise.
- Latency: start sampled at edge 0; digits are processed at edges 1..DIGITS; done is high in the cycle after edge DIGITS. Busy lasts DIGITS cycles and throughput is one operation per DIGITS+1 cycles.
- Outputs:
  - sum, cout and err hold their values in IDLE and DONE.
  - During RUN, sum shows the partial result: digits not yet processed read 0.
- Reset mid-RUN returns to IDLE with all outputs 0. No done pulse is produced for the aborted operation.
- DIGITS=1: exactly one RUN cycle, then DONE.

Test Plan:
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start for 1 cycle -> busy high for 4 cycles; done in the 5th cycle after start; sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1. Then hold start=1 continuously -> a new operation is accepted in every DONE cycle; done pulses every 5 cycles.
- Launch a=0x1111, b=0x2222, then pulse start with a=0x5555 while in RUN and change a/b mid-RUN -> result is sum=0x3333, exactly one done pulse.
- a=0x000A, b=0x0000, cin=0 -> err=1, sum=0x0010, cout=0. The next valid operation clears err.
- Assert rst for 1 cycle at the 2nd RUN cycle of 0x1234+0x5678 -> the next cycle shows state IDLE with busy=0, done=0, sum=0, cout=0, and no done pulse afterwards.
